// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 receiver for the FTDI debug link (ftdi_txd) feeding a first-word-fall-through byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing with a sticky parity_err output.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          pixclk,
  input  logic                          reset,
  input  logic                          ftdi_txd,
  input  logic                          clr_err,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun,
`ifdef UART_RX_PARITY_EN
  output logic                          parity_err,
`endif
  output logic                          busy
);

  localparam int DIV  = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int HALF = DIV / 2;
  localparam int TW   = $clog2(DIV + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;

  localparam logic [TW-1:0] T_LAST = TW'(DIV - 1);
  localparam logic [TW-1:0] T_VA   = TW'(HALF - 1);
  localparam logic [TW-1:0] T_VB   = TW'(HALF);
  localparam logic [TW-1:0] T_MID  = TW'(HALF + 1);

  // state   | meaning
  // S_IDLE  | line idle, waiting for a low level on rxs
  // S_START | start bit, midpoint vote rejects glitches
  // S_DATA  | eight data bits, LSB first
  // S_PARITY| even parity bit (parity build only)
  // S_STOP  | stop bit, good byte pushed at its midpoint
  // S_BREAK | bad stop bit, waiting for the line to return high
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t         state;
  logic           rx_meta, rxs;
  logic [TW-1:0]  timer;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           v_a, v_b;
  logic           at_mid, vote, push;
`ifdef UART_RX_PARITY_EN
  logic           par_bad;
`endif

  always_ff @(posedge pixclk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= ftdi_txd;
      rxs     <= rx_meta;
    end
  end

  assign at_mid = (timer == T_MID);
  assign vote   = (v_a & v_b) | (v_a & rxs) | (v_b & rxs);
  assign busy   = (state != S_IDLE);

  always_ff @(posedge pixclk) begin
    if (reset) begin
      state     <= S_IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      v_a       <= 1'b1;
      v_b       <= 1'b1;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      // The timer free-runs through the whole frame so midpoints stay DIV apart.
      if (state == S_IDLE || timer == T_LAST) timer <= '0;
      else                                     timer <= timer + 1'b1;
      if (timer == T_VA) v_a <= rxs;
      if (timer == T_VB) v_b <= rxs;
      if (clr_err) begin
        frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err <= 1'b0;
`endif
      end
      case (state)
        S_IDLE:
          if (!rxs) state <= S_START;
        S_START:
          if (at_mid) begin
            if (vote) state <= S_IDLE;
            else begin
              state   <= S_DATA;
              bit_idx <= '0;
            end
          end
        S_DATA:
          if (at_mid) begin
            shreg   <= {vote, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bit_idx == 3'd7) state <= S_PARITY;
`else
            if (bit_idx == 3'd7) state <= S_STOP;
`endif
          end
`ifdef UART_RX_PARITY_EN
        S_PARITY:
          if (at_mid) begin
            par_bad <= (vote != ^shreg);
            if (vote != ^shreg) parity_err <= 1'b1;
            state <= S_STOP;
          end
`endif
        S_STOP:
          if (at_mid) begin
            if (vote) state <= S_IDLE;
            else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end
        S_BREAK:
          if (rxs) state <= S_IDLE;
        default:
          state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  assign push = (state == S_STOP) && at_mid && vote && !par_bad;
`else
  assign push = (state == S_STOP) && at_mid && vote;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          full, pop, wr_en;

  assign valid_o = (fifo_count != '0);
  assign full    = (fifo_count == CW'(FIFO_DEPTH));
  assign pop     = valid_o & ready_i;
  assign wr_en   = push & (~full | pop);
  assign data_o  = mem[rd_ptr];

  always_ff @(posedge pixclk) begin
    if (reset) begin
      mem        <= '{default: '0};
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      overrun    <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !wr_en) fifo_count <= fifo_count - 1'b1;
      if (clr_err) overrun <= 1'b0;
      if (push && full && !pop) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are serialised onto ftdi_txd, expected bytes queued,
// and a monitor checks every handshake pop against the queue.
module tb_uart_rx_fifo;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 62500;
  localparam int DEPTH  = 8;
  localparam int DIV    = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int HALF   = DIV / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS  = 10;
`else
  localparam int NBITS  = 9;
`endif
  // posedges from driving the start bit until valid_o is first seen high
  localparam int LAT    = 5 + HALF + NBITS * DIV;

  logic       pixclk = 1'b0;
  logic       reset;
  logic       txd;
  logic       clr;
  logic [7:0] data_o;
  logic       valid_o;
  wire        ready_i;
  logic [$clog2(DEPTH):0] fifo_count;
  logic       frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  logic ready_man, rnd_bit, rand_ready;
  assign ready_i = rand_ready ? rnd_bit : ready_man;

  int n_checks = 0;
  int n_err    = 0;
  logic [7:0] exp_q[$];

  uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .pixclk     (pixclk),
    .reset      (reset),
    .ftdi_txd   (txd),
    .clr_err    (clr),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  always #5 pixclk = ~pixclk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    txd = v;
    repeat (DIV) @(posedge pixclk);
    #1;
  endtask

  task automatic send_raw(input logic [7:0] b, input logic pbit, input int stop_low);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_RX_PARITY_EN
    bit_time(pbit);
`else
    if (pbit) txd = 1'b1;
`endif
    repeat (stop_low) bit_time(1'b0);
    bit_time(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_raw(b, ^b, 0);
  endtask

  task automatic idle(input int n);
    txd = 1'b1;
    repeat (n) @(posedge pixclk);
    #1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge pixclk); #1;
    clr = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    ready_man = 1'b1;
    while (fifo_count != 0 && n < 500) begin
      @(posedge pixclk); #1;
      n++;
    end
    ready_man = 1'b0;
    chk(name, fifo_count, 0);
  endtask

  initial begin
    rnd_bit = 1'b0;
    forever begin
      @(posedge pixclk); #1;
      rnd_bit = 1'($urandom_range(0, 1));
    end
  end

  // monitor: every accepted handshake must match the oldest expected byte
  initial begin
    forever begin
      @(negedge pixclk);
      if (reset !== 1'b1 && valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL pop_unexpected: got 0x%0h, expected no byte", data_o);
        end else begin
          chk("pop_data", data_o, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    txd = 1'b1; clr = 1'b0; ready_man = 1'b0; rand_ready = 1'b0; reset = 1'b1;
    repeat (3) @(posedge pixclk); #1;
    chk("rst_data", data_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    idle(2);

    // single byte, exact latency
    exp_q.push_back(8'h4E);
    fork
      send_frame(8'h4E);
      begin
        repeat (LAT - 1) @(posedge pixclk); #1;
        chk("lat_before", valid_o, 0);
        @(posedge pixclk); #1;
        chk("lat_valid", valid_o, 1);
      end
    join
    chk("b4e_data", data_o, 8'h4E);
    chk("b4e_count", fifo_count, 1);
    chk("b4e_frame_err", frame_err, 0);
    chk("b4e_overrun", overrun, 0);
    ready_man = 1'b1;
    @(posedge pixclk); #1;
    ready_man = 1'b0;
    chk("b4e_valid_after_pop", valid_o, 0);
    chk("b4e_count_after_pop", fifo_count, 0);

    // start-bit glitch shorter than half a bit
    txd = 1'b0;
    repeat (HALF / 2) @(posedge pixclk); #1;
    txd = 1'b1;
    chk("glitch_busy", busy, 1);
    repeat (10) @(posedge pixclk); #1;
    chk("glitch_idle", busy, 0);
    chk("glitch_count", fifo_count, 0);
    idle(DIV);

    // stop bit held low, then recovery and clear
    send_raw(8'hA5, ^8'hA5, 2);
    idle(DIV);
    chk("ferr_set", frame_err, 1);
    chk("ferr_count", fifo_count, 0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C);
    chk("ferr_next_count", fifo_count, 1);
    chk("ferr_next_data", data_o, 8'h3C);
    chk("ferr_sticky", frame_err, 1);
    ready_man = 1'b1;
    @(posedge pixclk); #1;
    ready_man = 1'b0;
    pulse_clr();
    chk("ferr_cleared", frame_err, 0);

    // overflow: nine back-to-back bytes into an eight-deep FIFO
    for (int i = 0; i < 9; i++) begin
      if (i < DEPTH) exp_q.push_back(8'(i));
      send_frame(8'(i));
    end
    chk("ovr_count", fifo_count, DEPTH);
    chk("ovr_flag", overrun, 1);
    chk("ovr_head", data_o, 8'h00);
    drain("ovr_drain");
    pulse_clr();
    chk("ovr_cleared", overrun, 0);

    // full FIFO with a pop in the push cycle of the ninth byte
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b);
    end
    chk("wrap_full", fifo_count, DEPTH);
    b = 8'($urandom);
    exp_q.push_back(b);
    fork
      send_frame(b);
      begin
        repeat (LAT - 1) @(posedge pixclk); #1;
        ready_man = 1'b1;
        @(posedge pixclk); #1;
        ready_man = 1'b0;
      end
    join
    chk("wrap_count", fifo_count, DEPTH);
    chk("wrap_no_overrun", overrun, 0);
    drain("wrap_drain");

    // reset in the middle of a frame empties the FIFO and drops the partial byte
    exp_q.push_back(8'h11);
    send_frame(8'h11);
    chk("mid_count_before", fifo_count, 1);
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b0);
    reset = 1'b1;
    txd = 1'b1;
    @(posedge pixclk); #1;
    reset = 1'b0;
    exp_q.delete();
    chk("mid_busy", busy, 0);
    chk("mid_count", fifo_count, 0);
    chk("mid_valid", valid_o, 0);
    idle(3 * DIV);
    chk("mid_no_push", fifo_count, 0);

`ifdef UART_RX_PARITY_EN
    exp_q.push_back(8'h07);
    send_raw(8'h07, 1'b1, 0);
    chk("par_good_count", fifo_count, 1);
    chk("par_good_flag", parity_err, 0);
    drain("par_good_drain");
    send_raw(8'h07, 1'b0, 0);
    idle(2);
    chk("par_bad_flag", parity_err, 1);
    chk("par_bad_count", fifo_count, 0);
    pulse_clr();
    chk("par_cleared", parity_err, 0);
`endif

    // random bytes, random gaps, random consumer
    rand_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b);
      idle($urandom_range(0, 20));
    end
    rand_ready = 1'b0;
    drain("rand_drain");
    chk("rand_overrun", overrun, 0);
    chk("rand_frame_err", frame_err, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
